// File: rtl/pulse_burst_arbiter_if.sv
// Requester bus plus the control/feedback wires of the shared pulse generator.
// The arbiter takes the master side; requesters and the generator sit on the slave side.
interface pulse_burst_arbiter_if #(
    parameter int N = 8,
    parameter int C = 8,
    parameter int R = 4
);
    logic [R-1:0]   req;
    logic [R*N-1:0] period;
    logic [R*C-1:0] count;
    logic [R-1:0]   grant;
    logic [R-1:0]   done;
    logic           busy;
    logic           pulse_out;
    logic           pg_rst;
    logic           pg_ena;
    logic [N-1:0]   pg_ticks;
    logic           pg_out;

    modport master (
        input  req, period, count, pg_out,
        output grant, done, busy, pulse_out, pg_rst, pg_ena, pg_ticks
    );

    modport slave (
        output req, period, count, pg_out,
        input  grant, done, busy, pulse_out, pg_rst, pg_ena, pg_ticks
    );
endinterface

// File: rtl/pulse_burst_arbiter.sv
// Round-robin sequencer sharing one pulse generator among R burst requesters:
// grant, clear/load the generator, count its pulses, then strobe done.
module pulse_burst_arbiter #(
    parameter int N = 8,
    parameter int C = 8,
    parameter int R = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    pulse_burst_arbiter_if.master bus
);
    localparam int IW = (R > 1) ? $clog2(R) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] last_q, own_q, win, cand;
    logic          win_vld;
    logic [N-1:0]  per_q, win_per;
    logic [C-1:0]  rem_q, win_cnt;
    logic [R-1:0]  grant_q, done_q;
    logic          busy;

    // Search starts just after the previous winner and wraps, so every requester gets a turn.
    always_comb begin : rr_pick
        // NOTE: every variable is defaulted before any branch so no path leaves it
        // unassigned, which would otherwise infer a latch.
        win     = last_q;
        win_vld = 1'b0;
        cand    = last_q;
        for (int i = 1; i <= R; i++) begin
            cand = IW'((int'(last_q) + i) % R);
            if (!win_vld && bus.req[cand]) begin
                win     = cand;
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin : win_fields
        win_per = '0;
        win_cnt = '0;
        for (int i = 0; i < R; i++) begin
            if (IW'(i) == win) begin
                win_per = bus.period[i*N +: N];
                win_cnt = bus.count[i*C +: C];
            end
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            S_IDLE: if (win_vld) state_d = (win_cnt == '0) ? S_DONE : S_LOAD;
            S_LOAD: state_d = bus.req[own_q] ? S_RUN : S_IDLE;
            // Abort takes priority over completion: a dropped request never gets done.
            S_RUN: begin
                if (!bus.req[own_q])                    state_d = S_IDLE;
                else if (bus.pg_out && rem_q == C'(1))  state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            last_q  <= IW'(R - 1);
            own_q   <= '0;
            per_q   <= '0;
            rem_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            done_q  <= (state_d == S_DONE)
                       ? (R'(1) << ((state_q == S_IDLE) ? win : own_q)) : '0;
            grant_q <= (state_d == S_LOAD) ? (R'(1) << win)
                     : (state_d == S_RUN)  ? grant_q : '0;
            if (state_q == S_IDLE && win_vld) begin
                own_q  <= win;
                last_q <= win;
                per_q  <= win_per;
                rem_q  <= win_cnt;
            end else if (state_q == S_RUN && bus.pg_out) begin
                rem_q <= rem_q - C'(1);
            end
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign bus.busy      = busy;
    assign bus.grant     = grant_q;
    assign bus.done      = done_q;
    assign bus.pg_ena    = (state_q == S_RUN);
    assign bus.pulse_out = bus.pg_out & (state_q == S_RUN);
    // The generator is also held clear while the arbiter itself is in reset.
    assign bus.pg_rst    = (state_q == S_LOAD) | ~rst;
    assign bus.pg_ticks  = busy ? per_q : '0;
endmodule

// File: tb/tb_pulse_burst_arbiter.sv
// Bench for pulse_burst_arbiter: generator model, burst-level reference model checked
// every cycle, plus directed scenarios with hand-computed waveforms.
module tb_pulse_burst_arbiter;
    localparam int N = 8;
    localparam int C = 8;
    localparam int R = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pulse_burst_arbiter_if #(.N(N), .C(C), .R(R)) bus ();

    pulse_burst_arbiter #(.N(N), .C(C), .R(R)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Shared generator: first pulse P cycles after enable, then every P+1 cycles.
    logic [N-1:0] g_cnt;
    always @(posedge clk) begin
        if (bus.pg_rst)      g_cnt <= '0;
        else if (bus.pg_ena) g_cnt <= (g_cnt == bus.pg_ticks) ? '0 : g_cnt + 1'b1;
    end
    assign bus.pg_out = bus.pg_ena && (g_cnt == bus.pg_ticks);

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: cycle %0d got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: cycle %0d no response within bound", name, cyc);
    endtask

    // Inputs as seen by the DUT at each rising edge.
    logic [R-1:0]   req_s;
    logic [R*N-1:0] per_s;
    logic [R*C-1:0] cnt_s;
    logic           rst_s;
    always @(posedge clk) begin
        req_s <= bus.req;
        per_s <= bus.period;
        cnt_s <= bus.count;
        rst_s <= rst;
    end

    // Burst-level model: a granted burst is a set of cycle windows derived arithmetically.
    bit   b_valid = 1'b0;
    int   b_w, b_sel, b_p, b_k, b_load, b_rs, b_lp, b_done, b_end;
    int   m_last = R - 1;
    int   e, w, cand;
    logic [R-1:0] oh, x_grant, x_done;
    logic         x_busy, x_ena, x_pulse, x_rst;
    logic [N-1:0] x_ticks;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            e = cyc - 1;
            if (!rst_s) begin
                b_valid = 1'b0;
                m_last  = R - 1;
            end else if (!b_valid || e >= b_end) begin
                if (|req_s) begin
                    w = -1;
                    for (int k = 1; k <= R; k++) begin
                        cand = (m_last + k) % R;
                        if (w < 0 && req_s[cand]) w = cand;
                    end
                    b_valid = 1'b1;
                    b_w     = w;
                    b_sel   = e;
                    m_last  = w;
                    b_p     = int'(per_s[w*N +: N]);
                    b_k     = int'(cnt_s[w*C +: C]);
                    if (b_k == 0) begin
                        b_load = -100; b_rs = -100; b_lp = -100;
                        b_done = e + 1;
                    end else begin
                        b_load = e + 1;
                        b_rs   = e + 2;
                        b_lp   = b_rs + b_p + (b_k - 1) * (b_p + 1);
                        b_done = b_lp + 1;
                    end
                    b_end = b_done + 1;
                end
            end else if (b_k != 0 && e >= b_load && e <= b_lp && !req_s[b_w]) begin
                b_lp   = e;
                b_done = -100;
                b_end  = e + 1;
            end

            if (rst && rst_s) begin
                x_grant = '0; x_done = '0; x_busy = 1'b0; x_ena = 1'b0;
                x_pulse = 1'b0; x_rst = 1'b0; x_ticks = '0;
                if (b_valid) begin
                    oh      = R'(1) << b_w;
                    x_busy  = (cyc > b_sel) && (cyc < b_end);
                    x_ena   = (b_k != 0) && (cyc >= b_rs) && (cyc <= b_lp);
                    x_pulse = x_ena && (((cyc - b_rs) % (b_p + 1)) == b_p);
                    x_rst   = (b_k != 0) && (cyc == b_load);
                    x_ticks = x_busy ? N'(b_p) : '0;
                    if (b_k != 0 && cyc >= b_load && cyc <= b_lp) x_grant = oh;
                    if (cyc == b_done) x_done = oh;
                end
                check("grant",     32'(bus.grant),     32'(x_grant));
                check("done",      32'(bus.done),      32'(x_done));
                check("busy",      32'(bus.busy),      32'(x_busy));
                check("pg_ena",    32'(bus.pg_ena),    32'(x_ena));
                check("pulse_out", 32'(bus.pulse_out), 32'(x_pulse));
                check("pg_rst",    32'(bus.pg_rst),    32'(x_rst));
                check("pg_ticks",  32'(bus.pg_ticks),  32'(x_ticks));
            end
        end
    end

    task automatic set_req(input int i, input int p, input int k);
        bus.period[i*N +: N] = N'(p);
        bus.count[i*C +: C]  = C'(k);
        bus.req[i]           = 1'b1;
    endtask

    // Records bit j of each mask in cycle start+j; drops req[i] at drop_at or on done[i].
    task automatic observe(input int i, input int n, input int drop_at,
                           output logic [15:0] gm, output logic [15:0] pm,
                           output logic [15:0] dm, output logic [15:0] bm,
                           output logic [15:0] em);
        gm = '0; pm = '0; dm = '0; bm = '0; em = '0;
        for (int j = 1; j <= n; j++) begin
            @(negedge clk);
            gm[j] = bus.grant[i];
            pm[j] = bus.pulse_out;
            dm[j] = bus.done[i];
            bm[j] = bus.busy;
            em[j] = bus.pg_ena;
            if (j == drop_at || bus.done[i]) bus.req[i] = 1'b0;
        end
    endtask

    task automatic wait_done(output int idx);
        idx = -1;
        for (int k = 0; k < 100 && idx < 0; k++) begin
            @(negedge clk);
            for (int i = 0; i < R; i++) if (bus.done[i]) idx = i;
        end
        if (idx < 0) timeout("wait_done");
    endtask

    task automatic wait_grant(output logic [R-1:0] g);
        g = '0;
        for (int k = 0; k < 100 && g == '0; k++) begin
            @(negedge clk);
            g = bus.grant;
        end
        if (g == '0) timeout("wait_grant");
    endtask

    logic [15:0] gm, pm, dm, bm, em;
    logic [15:0] order;
    logic [R-1:0] g;
    int idx;

    initial begin
        bus.req = '0; bus.period = '0; bus.count = '0;
        repeat (2) @(negedge clk);
        check("rst_grant",  32'(bus.grant),     32'h0);
        check("rst_done",   32'(bus.done),      32'h0);
        check("rst_busy",   32'(bus.busy),      32'h0);
        check("rst_pg_ena", 32'(bus.pg_ena),    32'h0);
        check("rst_ticks",  32'(bus.pg_ticks),  32'h0);
        check("rst_pulse",  32'(bus.pulse_out), 32'h0);
        check("rst_pg_rst", 32'(bus.pg_rst),    32'h1);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single burst P=3, K=2 from requester 0.
        set_req(0, 3, 2);
        observe(0, 11, 0, gm, pm, dm, bm, em);
        check("single_grant", 32'(gm), 32'h03FE);
        check("single_pulse", 32'(pm), 32'h0220);
        check("single_done",  32'(dm), 32'h0400);
        check("single_busy",  32'(bm), 32'h07FE);
        check("single_ena",   32'(em), 32'h03FC);

        // Abort: requester 1, P=2, K=3, dropped after the first pulse.
        @(negedge clk);
        set_req(1, 2, 3);
        observe(1, 9, 5, gm, pm, dm, bm, em);
        check("abort_grant", 32'(gm), 32'h003E);
        check("abort_pulse", 32'(pm), 32'h0010);
        check("abort_done",  32'(dm), 32'h0000);
        check("abort_busy",  32'(bm), 32'h003E);
        check("abort_ena",   32'(em), 32'h003C);

        // Fairness: last=2 then req=0101 must wrap to requester 0.
        set_req(2, 5, 0);
        wait_done(idx);
        check("fair_setup", 32'(idx), 32'd2);
        bus.req = '0;
        @(negedge clk);
        set_req(0, 1, 2);
        set_req(2, 1, 2);
        wait_grant(g);
        check("fair_wrap", 32'(g), 32'b0001);
        bus.req = '0;
        repeat (3) @(negedge clk);

        // Zero period, K=4, requester 3: four back-to-back pulses.
        set_req(3, 0, 4);
        observe(3, 7, 0, gm, pm, dm, bm, em);
        check("p0_grant", 32'(gm), 32'h003E);
        check("p0_pulse", 32'(pm), 32'h003C);
        check("p0_done",  32'(dm), 32'h0040);
        check("p0_busy",  32'(bm), 32'h007E);
        check("p0_ena",   32'(em), 32'h003C);

        // Round-robin with all four requesting.
        @(negedge clk);
        for (int i = 0; i < R; i++) set_req(i, 1, 1);
        order = '0;
        for (int k = 0; k < R; k++) begin
            wait_done(idx);
            order = {order[11:0], 4'(idx)};
            if (idx >= 0) bus.req[idx] = 1'b0;
        end
        check("rr_order", 32'(order), 32'h0123);
        repeat (2) @(negedge clk);
        for (int i = 0; i < R; i++) set_req(i, 1, 1);
        wait_grant(g);
        check("rr_restart", 32'(g), 32'b0001);
        bus.req = '0;
        repeat (3) @(negedge clk);

        // Zero count: done the cycle after selection, no grant, no pulses.
        set_req(0, 7, 0);
        observe(0, 3, 0, gm, pm, dm, bm, em);
        check("k0_grant", 32'(gm), 32'h0000);
        check("k0_pulse", 32'(pm), 32'h0000);
        check("k0_done",  32'(dm), 32'h0002);
        check("k0_busy",  32'(bm), 32'h0002);
        @(negedge clk);

        // Asynchronous reset in the middle of a RUN phase.
        set_req(2, 5, 3);
        repeat (4) @(negedge clk);
        check("pre_rst_ena", 32'(bus.pg_ena), 32'h1);
        #2 rst = 1'b0;
        #1;
        check("arst_grant",  32'(bus.grant),     32'h0);
        check("arst_busy",   32'(bus.busy),      32'h0);
        check("arst_pg_ena", 32'(bus.pg_ena),    32'h0);
        check("arst_ticks",  32'(bus.pg_ticks),  32'h0);
        check("arst_pulse",  32'(bus.pulse_out), 32'h0);
        check("arst_done",   32'(bus.done),      32'h0);
        check("arst_pg_rst", 32'(bus.pg_rst),    32'h1);
        bus.req = '0;
        set_req(0, 2, 1);
        set_req(3, 2, 1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        wait_grant(g);
        check("post_rst_grant", 32'(g), 32'b0001);
        wait_done(idx);
        check("post_rst_done0", 32'(idx), 32'd0);
        if (idx >= 0) bus.req[idx] = 1'b0;
        wait_done(idx);
        check("post_rst_done3", 32'(idx), 32'd3);
        bus.req = '0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/pulse_burst_arbiter.md
# pulse_burst_arbiter

Round-robin arbiter and sequencer that shares one `pulse_generator` instance among R requesters. Each requester asks for a burst of `count` pulses at a given period. The arbiter grants one requester at a time, loads and clears the generator, counts its output pulses, and signals completion. It sits between the etch-a-sketch control logic (cursor stepping, display refresh timers) and the single shared timebase.

## Interface
- `N`, 8: width of period / generator `ticks`
- `C`, 8: width of burst pulse count
- `R`, 4: number of requesters (≥2)

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req`  in  R  per-requester burst request, level, held until `done` or abort
- `period`  in  R*N  flattened; requester i uses bits [i*N +: N]
- `count`  in  R*C  flattened; requester i uses bits [i*C +: C]
- `grant`  out  R  one-hot current owner, registered
- `done`  out  R  one-cycle completion strobe, registered
- `busy`  out  1  high whenever state ≠ IDLE
- `pulse_out`  out  1  gated generator pulse (`pg_out` & state==RUN)
- `pg_rst`  out  1  sync active-high clear to generator
- `pg_ena`  out  1  generator enable
- `pg_ticks`  out  N  generator period
- `pg_out`  in  1  generator pulse output

## Operation
- States: IDLE, LOAD, RUN, DONE.
- IDLE: if any `req` bit is set, select a winner by round-robin. The search starts at `last+1` and wraps at R-1→0. On selection:
  - latch `period[w]` → `per_q` and `count[w]` → `rem_q`
  - set `grant` = onehot(w) and `last` = w
  - go to LOAD
- If the latched count is 0: go straight to DONE. `grant` is never asserted, no pulses occur, and `done[w]` still fires.
- LOAD (1 cycle): `pg_rst`=1, `pg_ena`=0. Next state RUN.
- RUN: `pg_ena`=1. On each cycle with `pg_out`=1, `rem_q` decrements. When `pg_out`=1 and `rem_q`==1, go to DONE.
- DONE (1 cycle): `done[w]`=1, `grant`=0, `pg_ena`=0. Next state IDLE.
- Abort: if `req[w]` drops during LOAD or RUN, go directly to IDLE. `grant` clears and no `done` is issued. `last` keeps w.
- `pg_ticks` = `per_q` whenever state ≠ IDLE, and 0 in IDLE.
- `pg_rst` = (state==LOAD) | ~`rst`. This holds the generator cleared during reset.
- `period`=0 is legal: the generator pulses every RUN cycle, so a burst of K takes K cycles.
- `req`/`period`/`count` changes during a burst are ignored, apart from the abort rule.
- Arithmetic: `rem_q` is C bits and never underflows, because exit happens at 1.

## Timing
- Reset (async, `rst`=0) drives:
  - state=IDLE
  - `grant`=0, `done`=0, `busy`=0, `pg_ena`=0, `pg_ticks`=0, `pulse_out`=0
  - `last`=R-1, so requester 0 has first priority
- Reset mid-burst discards the burst silently.
- `req` seen in IDLE at edge k gives `grant` high from cycle k+1 (LOAD). RUN starts at k+2.
- Generator behaviour: first pulse at RUN-start + P, then one pulse every P+1 cycles (P = latched period).
- Last pulse in cycle t gives `done` in cycle t+1 and IDLE in t+2. The next `grant` comes no earlier than t+3.
- `grant` is high exactly over the LOAD and RUN cycles.
- `pulse_out` is never high outside RUN, and never high for a non-owner.

## Test plan
- Single burst: `req`[0]=1 at cycle 0, P=3, count=2 → `grant`=0001 over cycles 1–9, `pulse_out` at 5 and 9, `done`[0] at 10, `busy` low at 11.
- Round-robin: `req`=1111 held, each with P=1 and count=1, requester dropping `req` after its `done` → grant order 0,1,2,3. Re-raising all `req` then gives 0 next.
- Fairness after mid-pointer: `last`=2 and `req`=0101 → requester 0 is granted (wrap), not 2.
- Zero count / zero period: count=0 → `done` in the cycle after selection with no `grant` and no pulses. P=0 with count=4 → four consecutive `pulse_out` cycles, then `done`.
- Abort: `req`[1] dropped in RUN after 1 of 3 pulses → `grant` clears the next cycle, no `done`[1], and `pg_ena`=0.
- Async reset mid-RUN: `rst` low between clock edges → outputs zero immediately and `pg_rst`=1. After release, the first request from 0 wins over a simultaneous request from 3.
